data_path_agc_mc: RTL and testbench

Parametrised multi-channel AGC gain stage for the uplink TDM IQ datapath. It applies a per-antenna-slot gain to a time-multiplexed IQ stream of `XNUM` channels per frame, with round-half-up and saturation. Gain updates are double-buffered so they only take effect at a frame head. It also provides a bypass mode, a sample-valid qualifier and a saturation event counter. It sits between the DDC output and the TDL framer, replacing the fixed-latency single-gain AGC stage.

---
 rtl/data_path_agc_mc.sv | 216 +++++++++++++++++++++
 tb/tb_data_path_agc_mc.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_path_agc_mc.sv
// data_path_agc_mc: multi-channel AGC gain stage for a TDM IQ stream.
// Applies a per-slot, frame-aligned, double-buffered gain with round-half-up
// and saturation, over a fixed 4-stage pipeline (S1 select, S2 multiply,
// S3 round, S4 clip/output). Also provides a bypass mode and a saturation
// event counter.
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   i_valid/i_data    input sample valid, {I, Q} with I in the upper half
//   i_fram_hd         frame head (slot 0), qualified by i_valid
//   i_ant8_sel        sideband, delayed with the data
//   i_gain            shadow gain bank, slot k at [k*GAIN_W +: GAIN_W]
//   i_gain_upd        request to load the shadow bank at the next frame head
//   i_bypass          static: pass data unmodified with the same latency
//   i_sat_clr         clears the saturation counter
//   o_valid/o_data    gained output sample
//   o_fram_hd/o_ant8_sel/o_slot  sideband aligned to o_data
//   o_sat_cnt         saturating count of clipped components
module data_path_agc_mc #(
  parameter int unsigned IQ_W      = 16,
  parameter int unsigned XNUM      = 8,
  parameter int unsigned GAIN_W    = 16,
  parameter int unsigned GAIN_FRAC = 14
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  i_valid,
  input  logic [2*IQ_W-1:0]                     i_data,
  input  logic                                  i_fram_hd,
  input  logic                                  i_ant8_sel,
  input  logic [XNUM*GAIN_W-1:0]                i_gain,
  input  logic                                  i_gain_upd,
  input  logic                                  i_bypass,
  input  logic                                  i_sat_clr,
  output logic                                  o_valid,
  output logic [2*IQ_W-1:0]                     o_data,
  output logic                                  o_fram_hd,
  output logic                                  o_ant8_sel,
  output logic [((XNUM>1)?$clog2(XNUM):1)-1:0]  o_slot,
  output logic [15:0]                           o_sat_cnt
);

  localparam int unsigned DATA_DW = 2 * IQ_W;
  localparam int unsigned SLOT_W  = (XNUM > 1) ? $clog2(XNUM) : 1;
  localparam int unsigned P_W     = IQ_W + GAIN_W + 1;
  localparam int unsigned S_W     = P_W + 1;
  localparam int unsigned R_W     = S_W - GAIN_FRAC;

  localparam logic [GAIN_W-1:0]     UNITY = GAIN_W'(1) << GAIN_FRAC;
  localparam logic signed [S_W-1:0] RND   = S_W'(1) << (GAIN_FRAC - 1);
  localparam logic signed [R_W-1:0] MAXV  = R_W'((2 ** (IQ_W - 1)) - 1);
  localparam logic signed [R_W-1:0] MINV  = -MAXV - R_W'(1);
  localparam logic [IQ_W-1:0]       MAXP  = {1'b0, {(IQ_W-1){1'b1}}};
  localparam logic [IQ_W-1:0]       MINP  = {1'b1, {(IQ_W-1){1'b0}}};

  // Slot tracking and gain bank
  logic [SLOT_W-1:0] slot;
  logic [SLOT_W-1:0] cur_slot;
  logic              pend;
  logic              load;
  logic [GAIN_W-1:0] act_gain [XNUM];
  logic [GAIN_W-1:0] sel_gain;

  // Pipeline registers
  logic               v1, v2, v3;
  logic               fh1, fh2, fh3;
  logic               a1, a2, a3;
  logic [SLOT_W-1:0]  slot1, slot2, slot3;
  logic [DATA_DW-1:0] d1, d2, d3;
  logic [GAIN_W-1:0]  g1;
  logic signed [P_W-1:0] p_i2, p_q2;
  logic signed [R_W-1:0] r_i3, r_q3;
  logic               sat_i4, sat_q4;

  // S1 combinational: slot of the incoming sample and its gain
  always_comb begin
    cur_slot = i_fram_hd ? '0 : slot;
    load     = i_valid & i_fram_hd & (pend | i_gain_upd);
    // The frame-head sample that triggers a load already uses the new bank
    sel_gain = load ? i_gain[int'(cur_slot)*GAIN_W +: GAIN_W] : act_gain[cur_slot];
  end

  // Slot counter, pending-update flag and active gain bank
  always_ff @(posedge clk) begin
    if (reset) begin
      slot <= '0;
      pend <= 1'b0;
      for (int k = 0; k < int'(XNUM); k++) act_gain[k] <= UNITY;
    end else begin
      if (i_valid) begin
        if (i_fram_hd)                         slot <= SLOT_W'(1);
        else if (slot == SLOT_W'(XNUM - 1))    slot <= '0;
        else                                   slot <= slot + SLOT_W'(1);
      end
      if (load) begin
        pend <= 1'b0;
        for (int k = 0; k < int'(XNUM); k++) act_gain[k] <= i_gain[k*GAIN_W +: GAIN_W];
      end else if (i_gain_upd) begin
        pend <= 1'b1;
      end
    end
  end

  // S1: register input, slot and selected gain
  always_ff @(posedge clk) begin
    if (reset) begin
      v1 <= 1'b0; fh1 <= 1'b0; a1 <= 1'b0;
      slot1 <= '0; d1 <= '0; g1 <= '0;
    end else begin
      v1    <= i_valid;
      fh1   <= i_valid & i_fram_hd;
      a1    <= i_valid & i_ant8_sel;
      slot1 <= cur_slot;
      d1    <= i_data;
      g1    <= sel_gain;
    end
  end

  // S2: signed multiply by the zero-extended gain
  logic signed [IQ_W-1:0] x_i1, x_q1;
  logic signed [P_W-1:0]  xi_ext, xq_ext, g_ext;
  always_comb begin
    x_i1   = d1[DATA_DW-1 -: IQ_W];
    x_q1   = d1[IQ_W-1:0];
    xi_ext = P_W'(x_i1);
    xq_ext = P_W'(x_q1);
    g_ext  = $signed(P_W'({1'b0, g1}));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v2 <= 1'b0; fh2 <= 1'b0; a2 <= 1'b0;
      slot2 <= '0; d2 <= '0; p_i2 <= '0; p_q2 <= '0;
    end else begin
      v2    <= v1;
      fh2   <= fh1;
      a2    <= a1;
      slot2 <= slot1;
      d2    <= d1;
      p_i2  <= xi_ext * g_ext;
      p_q2  <= xq_ext * g_ext;
    end
  end

  // S3: add half an LSB and arithmetic-shift (round half toward +inf)
  logic signed [S_W-1:0] sum_i, sum_q;
  always_comb begin
    sum_i = S_W'(p_i2) + RND;
    sum_q = S_W'(p_q2) + RND;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v3 <= 1'b0; fh3 <= 1'b0; a3 <= 1'b0;
      slot3 <= '0; d3 <= '0; r_i3 <= '0; r_q3 <= '0;
    end else begin
      v3    <= v2;
      fh3   <= fh2;
      a3    <= a2;
      slot3 <= slot2;
      d3    <= d2;
      r_i3  <= R_W'(sum_i >>> GAIN_FRAC);
      r_q3  <= R_W'(sum_q >>> GAIN_FRAC);
    end
  end

  // S4 combinational: clip each component to the IQ_W range
  logic [IQ_W-1:0] y_i, y_q;
  logic            clip_i, clip_q;
  always_comb begin
    y_i    = r_i3[IQ_W-1:0];
    y_q    = r_q3[IQ_W-1:0];
    clip_i = 1'b0;
    clip_q = 1'b0;
    if (r_i3 > MAXV)      begin y_i = MAXP; clip_i = 1'b1; end
    else if (r_i3 < MINV) begin y_i = MINP; clip_i = 1'b1; end
    if (r_q3 > MAXV)      begin y_q = MAXP; clip_q = 1'b1; end
    else if (r_q3 < MINV) begin y_q = MINP; clip_q = 1'b1; end
  end

  // S4: output register; o_data and o_slot hold across bubbles
  always_ff @(posedge clk) begin
    if (reset) begin
      o_valid    <= 1'b0;
      o_data     <= '0;
      o_fram_hd  <= 1'b0;
      o_ant8_sel <= 1'b0;
      o_slot     <= '0;
      sat_i4     <= 1'b0;
      sat_q4     <= 1'b0;
    end else begin
      o_valid    <= v3;
      o_fram_hd  <= v3 & fh3;
      o_ant8_sel <= v3 & a3;
      sat_i4     <= v3 & ~i_bypass & clip_i;
      sat_q4     <= v3 & ~i_bypass & clip_q;
      if (v3) begin
        o_data <= i_bypass ? d3 : {y_i, y_q};
        o_slot <= slot3;
      end
    end
  end

  // Saturation counter: one cycle behind the output; clear wins, sticks at max
  logic [1:0] sat_inc;
  always_comb sat_inc = 2'(sat_i4) + 2'(sat_q4);

  always_ff @(posedge clk) begin
    if (reset || i_sat_clr) begin
      o_sat_cnt <= '0;
    end else if (sat_inc != 2'd0) begin
      if (o_sat_cnt > (16'hFFFF - 16'(sat_inc))) o_sat_cnt <= 16'hFFFF;
      else                                       o_sat_cnt <= o_sat_cnt + 16'(sat_inc);
    end
  end

endmodule

// File: tb/tb_data_path_agc_mc.sv
// Self-checking bench for data_path_agc_mc: directed frames plus randomized
// traffic compared cycle by cycle against a behavioural reference model.
module tb_data_path_agc_mc;

  localparam int XN = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          i_valid = 1'b0;
  logic [31:0]   i_data = '0;
  logic          i_fram_hd = 1'b0;
  logic          i_ant8_sel = 1'b0;
  logic [127:0]  i_gain = '0;
  logic          i_gain_upd = 1'b0;
  logic          i_bypass = 1'b0;
  logic          i_sat_clr = 1'b0;
  logic          o_valid;
  logic [31:0]   o_data;
  logic          o_fram_hd;
  logic          o_ant8_sel;
  logic [2:0]    o_slot;
  logic [15:0]   o_sat_cnt;

  data_path_agc_mc dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_data(i_data),
    .i_fram_hd(i_fram_hd), .i_ant8_sel(i_ant8_sel), .i_gain(i_gain),
    .i_gain_upd(i_gain_upd), .i_bypass(i_bypass), .i_sat_clr(i_sat_clr),
    .o_valid(o_valid), .o_data(o_data), .o_fram_hd(o_fram_hd),
    .o_ant8_sel(o_ant8_sel), .o_slot(o_slot), .o_sat_cnt(o_sat_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  // Reference model state
  typedef struct {
    bit          v;
    bit          fh;
    bit          ant;
    int          slot;
    logic [31:0] data;
    int          sat;
  } exp_t;

  exp_t        q[$];
  int          m_slot;
  bit          m_pend;
  int          m_act [XN];
  longint      m_cnt;
  int          m_pending;
  logic [31:0] m_last;

  // Gain, round half up, clip; returns the output component and clip flag
  function automatic void gain_comp(input int x, input int g, output int y, output bit c);
    longint p, r;
    p = longint'(x) * longint'(g);
    r = (p + 8192) >>> 14;
    c = 1'b0;
    if (r > 32767)       begin y = 32767;  c = 1'b1; end
    else if (r < -32768) begin y = -32768; c = 1'b1; end
    else                 y = int'(r);
  endfunction

  function automatic exp_t bubble();
    exp_t e;
    e.v = 0; e.fh = 0; e.ant = 0; e.slot = 0; e.data = '0; e.sat = 0;
    return e;
  endfunction

  task automatic model_reset();
    m_slot = 0; m_pend = 0; m_cnt = 0; m_pending = 0; m_last = '0;
    for (int k = 0; k < XN; k++) m_act[k] = 16384;
    q.delete();
    repeat (3) q.push_back(bubble());
  endtask

  // Advance one clock: model the presented inputs, then compare outputs
  task automatic step();
    exp_t e;
    exp_t o;
    bit   load;
    bit   clr;
    int   s, yi, yq;
    bit   ci, cq;
    e = bubble();
    load = 0;
    clr = i_sat_clr;
    if (i_valid) begin
      s = i_fram_hd ? 0 : m_slot;
      load = i_fram_hd && (m_pend || i_gain_upd);
      if (load) for (int k = 0; k < XN; k++) m_act[k] = int'(i_gain[k*16 +: 16]);
      gain_comp(int'($signed(i_data[31:16])), m_act[s], yi, ci);
      gain_comp(int'($signed(i_data[15:0])), m_act[s], yq, cq);
      e.v = 1; e.fh = i_fram_hd; e.ant = i_ant8_sel; e.slot = s;
      if (i_bypass) begin
        e.data = i_data; e.sat = 0;
      end else begin
        e.data = {yi[15:0], yq[15:0]};
        e.sat = int'(ci) + int'(cq);
      end
      m_slot = i_fram_hd ? 1 : ((s == XN - 1) ? 0 : s + 1);
    end
    if (load) m_pend = 0;
    else if (i_gain_upd) m_pend = 1;

    @(posedge clk);
    #1;
    q.push_back(e);
    if (clr) m_cnt = 0;
    else begin
      m_cnt = m_cnt + m_pending;
      if (m_cnt > 65535) m_cnt = 65535;
    end
    m_pending = 0;
    if (q.size() == 4) begin
      o = q.pop_front();
      chk("o_valid", longint'(o_valid), longint'(o.v));
      if (o.v) begin
        chk("o_data", longint'(o_data), longint'(o.data));
        chk("o_slot", longint'(o_slot), longint'(o.slot));
        chk("o_fram_hd", longint'(o_fram_hd), longint'(o.fh));
        chk("o_ant8_sel", longint'(o_ant8_sel), longint'(o.ant));
        m_last = o.data;
        m_pending = o.sat;
      end else begin
        chk("o_fram_hd_idle", longint'(o_fram_hd), 0);
        chk("o_ant8_sel_idle", longint'(o_ant8_sel), 0);
        chk("o_data_hold", longint'(o_data), longint'(m_last));
      end
    end
    chk("o_sat_cnt", longint'(o_sat_cnt), m_cnt);
  endtask

  task automatic drive(input bit v, input int di, input int dq, input bit fh,
                       input bit ant, input bit upd, input bit clr);
    i_valid = v; i_data = {16'(di), 16'(dq)}; i_fram_hd = fh;
    i_ant8_sel = ant; i_gain_upd = upd; i_sat_clr = clr;
    step();
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_o_valid", longint'(o_valid), 0);
    chk("rst_o_data", longint'(o_data), 0);
    chk("rst_o_fram_hd", longint'(o_fram_hd), 0);
    chk("rst_o_ant8_sel", longint'(o_ant8_sel), 0);
    chk("rst_o_slot", longint'(o_slot), 0);
    chk("rst_o_sat_cnt", longint'(o_sat_cnt), 0);
    model_reset();
  endtask

  task automatic set_all_gains(input int g);
    for (int k = 0; k < XN; k++) i_gain[k*16 +: 16] = 16'(g);
  endtask

  function automatic int rand_gain();
    case ($urandom_range(0, 5))
      0: return 16384;
      1: return 8192;
      2: return 16383;
      3: return 32768;
      4: return 65535;
      default: return int'($urandom_range(0, 65535));
    endcase
  endfunction

  task automatic rand_cycles(input int n, input int valid_pct);
    for (int c = 0; c < n; c++) begin
      if ($urandom_range(0, 99) < 3) i_gain[$urandom_range(0, XN-1)*16 +: 16] = 16'(rand_gain());
      drive($urandom_range(0, 99) < valid_pct, int'($urandom_range(0, 65535)) - 32768,
            int'($urandom_range(0, 65535)) - 32768, $urandom_range(0, 99) < 8,
            $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 4,
            $urandom_range(0, 99) < 2);
    end
  endtask

  initial begin
    set_all_gains(16384);
    reset_dut();

    // Unity gain, continuous frames
    for (int f = 0; f < 3; f++)
      for (int s = 0; s < XN; s++) drive(1, 1000, -1000, s == 0, s[0], 0, 0);

    // Rounding gains loaded via a mid-frame update, applied next frame
    i_gain[2*16 +: 16] = 16'd8192;
    i_gain[3*16 +: 16] = 16'd16383;
    i_gain[1*16 +: 16] = 16'd8192;
    for (int f = 0; f < 3; f++)
      for (int s = 0; s < XN; s++)
        drive(1, (s == 3) ? 32767 : 3, -3, s == 0, 0, (f == 0) && (s == 4), 0);

    // Update coincident with the frame head applies to that frame
    i_gain[1*16 +: 16] = 16'd16384;
    for (int f = 0; f < 2; f++)
      for (int s = 0; s < XN; s++) drive(1, 301, -301, s == 0, 1, (f == 0) && (s == 0), 0);

    // Saturation at gain 2.0, clear on an increment cycle, resync at slot 5
    set_all_gains(32768);
    for (int c = 0; c < 24; c++)
      drive(1, 20000, -20000, (c % XN == 0) || (c == 21), 0, c == 0, c == 14);

    // Bubbles
    for (int c = 0; c < 40; c++)
      drive(($urandom_range(0, 2) != 0), 1000 + c, -c, c == 3, c[0], 0, 0);

    // Randomized traffic
    rand_cycles(2000, 80);

    // Drive the saturation counter to its ceiling
    set_all_gains(32768);
    drive(1, 20000, -20000, 1, 0, 1, 1);
    for (int c = 1; c < 33000; c++) drive(1, 20000, -20000, (c % XN) == 0, 0, 0, 0);
    for (int c = 0; c < 5; c++) drive(0, 0, 0, 0, 0, 0, 0);
    chk("sat_cnt_ceiling", longint'(o_sat_cnt), 65535);

    // Bypass with a gain that would saturate: data unchanged, nothing counted
    for (int c = 0; c < 4; c++) drive(0, 0, 0, 0, 0, 0, c == 0);
    i_bypass = 1'b1;
    drive(1, 20000, -20000, 1, 1, 0, 0);
    rand_cycles(300, 85);
    for (int c = 0; c < 5; c++) drive(0, 0, 0, 0, 0, 0, 0);
    i_bypass = 1'b0;

    // Reset mid-stream; slots restart at 0 before the next frame head
    rand_cycles(20, 100);
    i_valid = 1'b1;
    reset_dut();
    for (int c = 0; c < 12; c++) drive(1, 500, -500, 0, 0, 0, 0);
    rand_cycles(200, 75);
    for (int c = 0; c < 6; c++) drive(0, 0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
